uart_rx: RTL and testbench

//  UART receiver: 8N1-style serial in, parallel byte out. No parity; STOP_BITS configurable.

---
 rtl/uart_rx.sv | 149 ++++++++++++++
 tb/tb_uart_rx.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: asynchronous serial receiver. Frames are a start bit, DATA_BITS data
// bits (LSB first) and STOP_BITS stop bits, with no parity. Each bit is sampled
// near its centre by a counter that restarts on the start-bit falling edge. The
// received word is presented on a valid/ready holding register.
//
// Ports
//   clk          clock
//   n_reset      synchronous reset, active low
//   in           asynchronous serial line, idle high
//   data_out     received word, stable while valid is high
//   valid        data_out holds a word that has not been consumed yet
//   ready        consumer accepts; a transfer happens on valid && ready at a posedge
//   framing_err  one-cycle pulse: a stop-bit sample was 0, and the word is dropped
//   overrun      one-cycle pulse: a word completed while the holding register was
//                full, and the new word is dropped
module uart_rx #(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned CLKS_PER_BIT = 1000
) (
  input  logic                 clk,
  input  logic                 n_reset,
  input  logic                 in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  input  logic                 ready,
  output logic                 framing_err,
  output logic                 overrun
);

  localparam int unsigned HALF  = CLKS_PER_BIT / 2;
  localparam int unsigned SCW   = $clog2(CLKS_PER_BIT);
  localparam int unsigned MAXB  = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
  localparam int unsigned BCW   = $clog2(MAXB + 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t               state;
  logic                 s1;
  logic                 s2;
  logic                 s2_d;
  logic [SCW-1:0]       sample_ctr;
  logic [BCW-1:0]       bit_ctr;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 frame_bad;
  logic                 mid_bit;

  // In DATA and STOP, the sample point is the end of each full bit period.
  // START ends half a bit in, so that later samples land at the bit centre.
  assign mid_bit = (sample_ctr == SCW'(CLKS_PER_BIT - 1));

  // Synchroniser, receive state machine and output holding register.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state       <= IDLE;
      s1          <= 1'b1;
      s2          <= 1'b1;
      s2_d        <= 1'b1;
      sample_ctr  <= '0;
      bit_ctr     <= '0;
      shift_reg   <= '0;
      frame_bad   <= 1'b0;
      data_out    <= '0;
      valid       <= 1'b0;
      framing_err <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      s1          <= in;
      s2          <= s1;
      s2_d        <= s2;
      framing_err <= 1'b0;
      overrun     <= 1'b0;

      // A completion in the same cycle overrides this clear and loads the new word.
      if (valid && ready) valid <= 1'b0;

      case (state)
        IDLE: begin
          // Arm only on a high-to-low edge, so that a held-low line (break) stays idle.
          if (s2_d && !s2) begin
            state      <= START;
            sample_ctr <= '0;
            bit_ctr    <= '0;
          end
        end

        START: begin
          if (sample_ctr == SCW'(HALF - 1)) begin
            sample_ctr <= '0;
            bit_ctr    <= '0;
            // If the line is high again at mid start bit, it was a glitch and is ignored.
            state      <= s2 ? IDLE : DATA;
          end else begin
            sample_ctr <= sample_ctr + SCW'(1);
          end
        end

        DATA: begin
          if (mid_bit) begin
            sample_ctr <= '0;
            // LSB arrives first, so shifting right leaves bit 0 at the bottom after the last shift.
            shift_reg  <= (shift_reg >> 1) | (DATA_BITS'(s2) << (DATA_BITS - 1));
            if (bit_ctr == BCW'(DATA_BITS - 1)) begin
              state     <= STOP;
              bit_ctr   <= '0;
              frame_bad <= 1'b0;
            end else begin
              bit_ctr <= bit_ctr + BCW'(1);
            end
          end else begin
            sample_ctr <= sample_ctr + SCW'(1);
          end
        end

        STOP: begin
          if (mid_bit) begin
            sample_ctr <= '0;
            if (bit_ctr == BCW'(STOP_BITS - 1)) begin
              // Return mid stop bit, so the next start edge is not missed.
              state   <= IDLE;
              bit_ctr <= '0;
              if (frame_bad || !s2) begin
                framing_err <= 1'b1;
              end else if (!valid || ready) begin
                data_out <= shift_reg;
                valid    <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              bit_ctr   <= bit_ctr + BCW'(1);
              frame_bad <= frame_bad | !s2;
            end
          end else begin
            sample_ctr <= sample_ctr + SCW'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx. It drives serial frames from a behavioural transmitter
// and compares the received words and error pulses against queues of expected
// results. Instance dut1 has one stop bit. Instance dut2 has two stop bits and
// takes the random loopback traffic.
module tb_uart_rx;

  localparam int unsigned CPB  = 16;
  localparam int unsigned DB   = 8;
  localparam int unsigned HALF = CPB / 2;
  // Cycles from the line falling edge to the final stop-bit sample (one stop bit):
  // 2 synchroniser stages + 1 edge detect + half a bit + (data + stop) full bits.
  localparam int unsigned COMPLETE = 2 + 1 + HALF + CPB * (DB + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       n_reset;
  logic       line1, ready1, valid1, fe1, ov1;
  logic       line2, ready2, valid2, fe2, ov2;
  logic [7:0] dout1, dout2;

  uart_rx #(.DATA_BITS(DB), .STOP_BITS(1), .CLKS_PER_BIT(CPB)) dut1 (
    .clk(clk), .n_reset(n_reset), .in(line1), .data_out(dout1), .valid(valid1),
    .ready(ready1), .framing_err(fe1), .overrun(ov1)
  );

  uart_rx #(.DATA_BITS(DB), .STOP_BITS(2), .CLKS_PER_BIT(CPB)) dut2 (
    .clk(clk), .n_reset(n_reset), .in(line2), .data_out(dout2), .valid(valid2),
    .ready(ready2), .framing_err(fe2), .overrun(ov2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: sampled on the falling edge, while inputs and outputs are stable.
  logic [7:0] got1[$];
  logic [7:0] got2[$];
  int fe1_cnt = 0, ov1_cnt = 0, vcyc1 = 0, fe2_cnt = 0, ov2_cnt = 0;

  always @(negedge clk) begin
    if (valid1 && ready1) got1.push_back(dout1);
    if (valid2 && ready2) got2.push_back(dout2);
    if (valid1) vcyc1++;
    if (fe1) fe1_cnt++;
    if (ov1) ov1_cnt++;
    if (fe2) fe2_cnt++;
    if (ov2) ov2_cnt++;
  end

  // Random consumer for dut2.
  initial begin
    ready2 = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      ready2 = ($urandom_range(3) != 0);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit sel, input logic v);
    if (sel) line2 = v;
    else     line1 = v;
  endtask

  task automatic send(input bit sel, input logic [7:0] b, input logic stop_v, input int nstop);
    drive(sel, 1'b0);
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      drive(sel, b[i]);
      tick(CPB);
    end
    for (int i = 0; i < nstop; i++) begin
      drive(sel, stop_v);
      tick(CPB);
    end
  endtask

  int         b0, f0, o0, v0, t5_gap, nbad, gap;
  logic [7:0] exp1[$];
  logic [7:0] exp2[$];
  logic [7:0] rb;
  logic       bad;

  initial begin
    n_reset = 1'b0;
    line1   = 1'b1;
    line2   = 1'b1;
    ready1  = 1'b0;
    t5_gap  = 0;
    tick(3);
    check("rst_valid", 32'(valid1), 32'd0);
    check("rst_data", 32'(dout1), 32'd0);
    check("rst_ferr", 32'(fe1), 32'd0);
    check("rst_ovr", 32'(ov1), 32'd0);
    check("rst_valid2", 32'(valid2), 32'd0);
    n_reset = 1'b1;
    tick(4);

    // 1: a clean frame with ready held high
    ready1 = 1'b1;
    b0 = got1.size(); f0 = fe1_cnt; o0 = ov1_cnt; v0 = vcyc1;
    send(0, 8'hA5, 1'b1, 1);
    tick(2 * CPB);
    check("t1_count", 32'(got1.size() - b0), 32'd1);
    if (got1.size() > b0) check("t1_data", 32'(got1[b0]), 32'hA5);
    check("t1_valid_cycles", 32'(vcyc1 - v0), 32'd1);
    check("t1_flags", 32'(fe1_cnt - f0 + ov1_cnt - o0), 32'd0);

    // 2: a 5-cycle low glitch is rejected
    b0 = got1.size(); f0 = fe1_cnt; o0 = ov1_cnt; v0 = vcyc1;
    line1 = 1'b0;
    tick(5);
    line1 = 1'b1;
    tick(2 * CPB);
    check("t2_valid_cycles", 32'(vcyc1 - v0), 32'd0);
    check("t2_flags", 32'(fe1_cnt - f0 + ov1_cnt - o0), 32'd0);

    // 3: a bad stop bit, then recovery
    send(0, 8'h3C, 1'b0, 1);
    line1 = 1'b1;
    tick(CPB);
    check("t3_ferr", 32'(fe1_cnt - f0), 32'd1);
    check("t3_valid_cycles", 32'(vcyc1 - v0), 32'd0);
    send(0, 8'h11, 1'b1, 1);
    tick(2 * CPB);
    check("t3_count", 32'(got1.size() - b0), 32'd1);
    if (got1.size() > b0) check("t3_data", 32'(got1[b0]), 32'h11);

    // 4: overrun on back-to-back frames with ready low
    ready1 = 1'b0;
    f0 = fe1_cnt; o0 = ov1_cnt;
    send(0, 8'h01, 1'b1, 1);
    send(0, 8'h02, 1'b1, 1);
    tick(2 * CPB);
    check("t4_valid", 32'(valid1), 32'd1);
    check("t4_data", 32'(dout1), 32'h01);
    check("t4_ovr", 32'(ov1_cnt - o0), 32'd1);
    check("t4_ferr", 32'(fe1_cnt - f0), 32'd0);
    ready1 = 1'b1;
    tick(1);
    check("t4_valid_drop", 32'(valid1), 32'd0);
    ready1 = 1'b0;

    // 5: accept in the exact completion cycle
    b0 = got1.size(); o0 = ov1_cnt;
    send(0, 8'h44, 1'b1, 1);
    tick(CPB);
    check("t5_hold_valid", 32'(valid1), 32'd1);
    check("t5_hold_data", 32'(dout1), 32'h44);
    fork
      send(0, 8'h55, 1'b1, 1);
      begin
        tick(COMPLETE - 1);
        ready1 = 1'b1;
        tick(1);
        ready1 = 1'b0;
      end
      begin
        tick(COMPLETE - 4);
        repeat (8) begin
          @(negedge clk);
          if (!valid1) t5_gap++;
        end
      end
    join
    tick(CPB);
    check("t5_valid_gap", 32'(t5_gap), 32'd0);
    check("t5_ovr", 32'(ov1_cnt - o0), 32'd0);
    check("t5_valid", 32'(valid1), 32'd1);
    check("t5_data", 32'(dout1), 32'h55);
    check("t5_count", 32'(got1.size() - b0), 32'd1);
    if (got1.size() > b0) check("t5_consumed", 32'(got1[b0]), 32'h44);

    // 6: reset during data bit 3
    f0 = fe1_cnt; o0 = ov1_cnt;
    fork
      send(0, 8'hFF, 1'b1, 1);
      begin
        tick(CPB * 4 + 6);
        n_reset = 1'b0;
        tick(2);
        check("t6_rst_valid", 32'(valid1), 32'd0);
        check("t6_rst_data", 32'(dout1), 32'd0);
        check("t6_rst_flags", 32'({fe1, ov1}), 32'd0);
        n_reset = 1'b1;
      end
    join
    tick(CPB);
    check("t6_no_frame", 32'(valid1), 32'd0);
    check("t6_flags", 32'(fe1_cnt - f0 + ov1_cnt - o0), 32'd0);
    ready1 = 1'b1;
    b0 = got1.size();
    send(0, 8'h81, 1'b1, 1);
    tick(2 * CPB);
    check("t6_count", 32'(got1.size() - b0), 32'd1);
    if (got1.size() > b0) check("t6_data", 32'(got1[b0]), 32'h81);

    // Random frames on dut1, some with a bad stop bit
    b0 = got1.size(); f0 = fe1_cnt; o0 = ov1_cnt; nbad = 0;
    for (int n = 0; n < 40; n++) begin
      rb  = 8'($urandom);
      bad = ($urandom_range(7) == 0);
      send(0, rb, !bad, 1);
      if (bad) begin
        nbad++;
        line1 = 1'b1;
        tick(CPB);
      end else begin
        exp1.push_back(rb);
        gap = $urandom_range(20);
        if (gap > 0) tick(gap);
      end
    end
    tick(2 * CPB);
    check("r1_count", 32'(got1.size() - b0), 32'(exp1.size()));
    for (int i = 0; i < exp1.size(); i++)
      if (b0 + i < got1.size()) check("r1_data", 32'(got1[b0 + i]), 32'(exp1[i]));
    check("r1_ferr", 32'(fe1_cnt - f0), 32'(nbad));
    check("r1_ovr", 32'(ov1_cnt - o0), 32'd0);

    // Loopback with two stop bits: 256 random bytes, in order
    for (int n = 0; n < 256; n++) begin
      rb = 8'($urandom);
      exp2.push_back(rb);
      send(1, rb, 1'b1, 2);
      gap = $urandom_range(12);
      if (gap > 0) tick(gap);
    end
    tick(3 * CPB);
    check("lb_count", 32'(got2.size()), 32'd256);
    for (int i = 0; i < exp2.size(); i++)
      if (i < got2.size()) check("lb_data", 32'(got2[i]), 32'(exp2[i]));
    check("lb_ferr", 32'(fe2_cnt), 32'd0);
    check("lb_ovr", 32'(ov2_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
